spi_shift_engine: RTL

Parametrised SPI data shifter that serialises one transmit word and deserialises one receive word in a single register. It adds bit counting, MSB/LSB-first selection, separate sample/shift strobes for SPI mode handling, busy/done handshake and abort. It sits between the SPI clock generator, which supplies the strobes, and the SPI master/slave control FSM.

---
 rtl/spi_shift_engine_if.sv | 25 ++
 rtl/spi_shift_engine.sv | 102 ++++++++++
 2 files changed

// File: rtl/spi_shift_engine_if.sv
// Control-side bundle for spi_shift_engine.
// The master modport is the SPI control FSM; the slave modport is the engine.
interface spi_shift_engine_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              Start;
  logic              LsbFirst;
  logic [DATA_W-1:0] TxData;
  logic              Abort;
  logic [DATA_W-1:0] RxData;
  logic              Busy;
  logic              Done;
  logic [CNT_W-1:0]  BitCnt;

  modport master (
    output Start, LsbFirst, TxData, Abort,
    input  RxData, Busy, Done, BitCnt
  );

  modport slave (
    input  Start, LsbFirst, TxData, Abort,
    output RxData, Busy, Done, BitCnt
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI shift engine: one register serialises TxData and deserialises SerIn.
// Strobes come from the SPI clock generator; control via spi_shift_engine_if.
module spi_shift_engine #(
  parameter int   DATA_W   = 8,
  parameter int   CNT_W    = $clog2(DATA_W + 1),
  parameter logic IDLE_OUT = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  spi_shift_engine_if.slave     ctl,
  input  logic                  SampleStb,
  input  logic                  ShiftStb,
  input  logic                  SerIn,
  output logic                  SerOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t            state, nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_nxt;
  logic [DATA_W-1:0] rx_q;
  logic [CNT_W-1:0]  cnt;
  logic              latch;
  logic              dir;
  logic              in_bit;
  logic              last;

  // Coincident strobes take SerIn directly instead of the stale latch
  assign in_bit = SampleStb ? SerIn : latch;
  assign last   = (cnt == CNT_W'(DATA_W - 1));
  assign sh_nxt = dir ? {in_bit, shreg[DATA_W-1:1]}
                      : {shreg[DATA_W-2:0], in_bit};

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (ctl.Start) nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (ctl.Abort)           nxt = S_IDLE;
        else if (ShiftStb && last) nxt = S_DONE;
      end
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      rx_q  <= '0;
      cnt   <= '0;
      latch <= 1'b0;
      dir   <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (ctl.Start) begin
            shreg <= ctl.TxData;
            dir   <= ctl.LsbFirst;
            cnt   <= '0;
            latch <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (ctl.Abort) begin
            cnt <= '0;
          end else begin
            if (SampleStb) latch <= SerIn;
            if (ShiftStb) begin
              shreg <= sh_nxt;
              cnt   <= cnt + CNT_W'(1);
              if (last) rx_q <= sh_nxt;
            end
          end
        end
        S_DONE: begin
          if (ctl.Abort) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SerOut = IDLE_OUT;
    if (state == S_ACTIVE)
      SerOut = dir ? shreg[0] : shreg[DATA_W-1];
  end

  assign ctl.Busy   = (state != S_IDLE);
  assign ctl.Done   = (state == S_DONE);
  assign ctl.BitCnt = cnt;
  assign ctl.RxData = rx_q;

endmodule
